adc_pattern_checker: RTL and testbench

//  Consumes the parallel 8-bit ADC sample stream while the SPI configurator
//  has the converter in a digital test mode, and checks every sample against
//  the expected pattern. Reports error count, pass/fail and done to the LEDs/debug.

---
 rtl/adc_pattern_checker_if.sv | 25 ++
 rtl/adc_pattern_checker.sv | 161 ++++++++++++++++
 tb/tb_adc_pattern_checker.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pattern_checker_if.sv
// Sample-stream / result bundle between the ADC test-mode sequencer side and the pattern checker.
// The master drives samples and mode commits; the slave (checker) returns status.
interface adc_pattern_checker_if #(
  parameter int ERR_W = 16
);
  logic [7:0]       adc_data;
  logic             adc_valid;
  logic [7:0]       test_mode;
  logic             mode_update;
  logic             busy;
  logic             done;
  logic             pass;
  logic             unsupported;
  logic [ERR_W-1:0] err_count;

  modport master (
    output adc_data, adc_valid, test_mode, mode_update,
    input  busy, done, pass, unsupported, err_count
  );

  modport slave (
    input  adc_data, adc_valid, test_mode, mode_update,
    output busy, done, pass, unsupported, err_count
  );
endinterface

// File: rtl/adc_pattern_checker.sv
// Checks the ADC digital test-pattern stream after a mode commit: flushes the
// converter pipeline, locks alternating patterns, then counts mismatching samples.
module adc_pattern_checker #(
  parameter int SETTLE_SAMPLES = 16,
  parameter int CHECK_SAMPLES  = 1024,
  parameter int ERR_W          = 16
) (
  input logic                  clk,
  input logic                  rst,
  adc_pattern_checker_if.slave bus
);
  localparam int DATA_W = 8;
  localparam int SET_W  = $clog2(SETTLE_SAMPLES + 1);
  localparam int CHK_W  = $clog2(CHECK_SAMPLES + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, LOCK, CHECK, DONE} state_t;

  function automatic logic is_supported(input logic [DATA_W-1:0] code);
    return (code == 8'h01) || (code == 8'h02) || (code == 8'h03) ||
           (code == 8'h04) || (code == 8'h07);
  endfunction

  function automatic logic is_alternating(input logic [DATA_W-1:0] code);
    return (code == 8'h04) || (code == 8'h07);
  endfunction

  function automatic logic [DATA_W-1:0] static_value(input logic [DATA_W-1:0] code);
    logic [DATA_W-1:0] v;
    case (code)
      8'h01:   v = 8'h80;
      8'h02:   v = 8'hFF;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // sel=0 is phase A (0x55 / 0x00), sel=1 is phase B (0xAA / 0xFF)
  function automatic logic [DATA_W-1:0] alt_value(input logic [DATA_W-1:0] code,
                                                  input logic sel);
    logic [DATA_W-1:0] v;
    if (code == 8'h04) v = sel ? 8'hAA : 8'h55;
    else               v = sel ? 8'hFF : 8'h00;
    return v;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            state;
  logic [DATA_W-1:0] mode;
  logic [SET_W-1:0]  settle_cnt;
  logic [CHK_W-1:0]  check_cnt;
  logic              phase;
  logic              busy;
  logic              done;
  logic              unsupported;
  logic [ERR_W-1:0]  err_count;
  logic [DATA_W-1:0] expected;
  logic              lock_mismatch;
  logic              vld_p0;
  logic              last_p0;
  logic              mismatch_p0;
  logic              last_p1;

  assign expected = is_alternating(mode) ? alt_value(mode, phase) : static_value(mode);

  // The lock sample only errs on alternating modes if it matches neither phase
  assign lock_mismatch = is_alternating(mode)
    ? !((bus.adc_data == alt_value(mode, 1'b0)) || (bus.adc_data == alt_value(mode, 1'b1)))
    : (bus.adc_data != static_value(mode));

  // Stage p0: compare result, qualified by vld_p0 from the control block
  always_ff @(posedge clk) begin
    mismatch_p0 <= (state == LOCK) ? lock_mismatch : (bus.adc_data != expected);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode        <= '0;
      settle_cnt  <= '0;
      check_cnt   <= '0;
      phase       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      unsupported <= 1'b0;
      err_count   <= '0;
      vld_p0      <= 1'b0;
      last_p0     <= 1'b0;
      last_p1     <= 1'b0;
    end else if (bus.mode_update) begin
      // Abort whatever is running; in-flight compares are discarded with it
      mode       <= bus.test_mode;
      settle_cnt <= '0;
      check_cnt  <= '0;
      phase      <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      vld_p0     <= 1'b0;
      last_p0    <= 1'b0;
      last_p1    <= 1'b0;
      if (is_supported(bus.test_mode)) begin
        state       <= SETTLE;
        busy        <= 1'b1;
        unsupported <= 1'b0;
      end else begin
        state       <= IDLE;
        busy        <= 1'b0;
        unsupported <= 1'b1;
      end
    end else begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      // Stage p1: accumulate errors and retire the final compare
      if (vld_p0 && mismatch_p0) err_count <= sat_inc(err_count);
      last_p1 <= vld_p0 && last_p0;

      case (state)
        SETTLE: begin
          if (bus.adc_valid) begin
            if (settle_cnt == SET_W'(SETTLE_SAMPLES - 1)) begin
              state      <= LOCK;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        LOCK: begin
          if (bus.adc_valid) begin
            vld_p0    <= 1'b1;
            last_p0   <= (CHECK_SAMPLES == 1);
            check_cnt <= CHK_W'(1);
            phase     <= (bus.adc_data != alt_value(mode, 1'b1));
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (last_p1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (bus.adc_valid && (check_cnt != CHK_W'(CHECK_SAMPLES))) begin
            vld_p0    <= 1'b1;
            last_p0   <= (check_cnt == CHK_W'(CHECK_SAMPLES - 1));
            check_cnt <= check_cnt + 1'b1;
            phase     <= ~phase;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.pass        = done && (err_count == '0);
  assign bus.unsupported = unsupported;
  assign bus.err_count   = err_count;
endmodule

// File: tb/tb_adc_pattern_checker.sv
// Randomized and directed bench for adc_pattern_checker, with an index-based
// reference model of the expected pattern and output latencies.
module tb_adc_pattern_checker;
  localparam int SETTLE = 16;
  localparam int CHECK  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adc_pattern_checker_if #(.ERR_W(16)) bus16 ();
  adc_pattern_checker_if #(.ERR_W(4))  bus4 ();

  assign bus4.adc_data    = bus16.adc_data;
  assign bus4.adc_valid   = bus16.adc_valid;
  assign bus4.test_mode   = bus16.test_mode;
  assign bus4.mode_update = bus16.mode_update;

  adc_pattern_checker #(.SETTLE_SAMPLES(SETTLE), .CHECK_SAMPLES(CHECK), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus16)
  );
  adc_pattern_checker #(.SETTLE_SAMPLES(SETTLE), .CHECK_SAMPLES(CHECK), .ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mode, m_idx, m_err, m_first;
  bit m_run, m_unsup, m_done;
  int e_h[3];
  bit d_h[3], r_h[3], u_h[3], mu_h[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit supported(input int code);
    return code == 1 || code == 2 || code == 3 || code == 4 || code == 7;
  endfunction

  function automatic int pattern_value(input int code, input int k, input int first);
    if (code == 1) return 8'h80;
    if (code == 2) return 8'hFF;
    if (code == 3) return 8'h00;
    if (code == 4) return ((first + k - 1) % 2) ? 8'hAA : 8'h55;
    return ((first + k - 1) % 2) ? 8'hFF : 8'h00;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_err = 0; m_first = 0;
    m_run = 0; m_unsup = 0; m_done = 0;
    for (int i = 0; i < 3; i++) begin
      e_h[i] = 0; d_h[i] = 0; r_h[i] = 0; u_h[i] = 0; mu_h[i] = 0;
    end
  endtask

  task automatic model_step(input bit mu, input int tm, input bit v, input int d);
    int k;
    if (mu) begin
      m_mode = tm; m_idx = 0; m_err = 0; m_done = 0; m_first = 0;
      m_run = supported(tm); m_unsup = !m_run;
    end else if (v && m_run && !m_done) begin
      m_idx++;
      if (m_idx > SETTLE) begin
        k = m_idx - SETTLE;
        if ((m_mode == 4 || m_mode == 7) && k == 1) begin
          m_first = (d == pattern_value(m_mode, 2, 0)) ? 1 : 0;
          if (d != pattern_value(m_mode, 1, 0) && d != pattern_value(m_mode, 2, 0)) m_err++;
        end else if (d != pattern_value(m_mode, k, m_first)) begin
          m_err++;
        end
        if (k == CHECK) m_done = 1;
      end
    end
    for (int i = 2; i > 0; i--) begin
      e_h[i] = e_h[i-1]; d_h[i] = d_h[i-1]; r_h[i] = r_h[i-1];
      u_h[i] = u_h[i-1]; mu_h[i] = mu_h[i-1];
    end
    e_h[0] = m_err; d_h[0] = m_done; r_h[0] = m_run; u_h[0] = m_unsup; mu_h[0] = mu;
  endtask

  task automatic compare_outputs();
    int exp_err;
    bit exp_done;
    exp_err  = mu_h[0] ? 0 : e_h[1];
    exp_done = (mu_h[0] || mu_h[1]) ? 1'b0 : d_h[2];
    chk("err_count", int'(bus16.err_count), exp_err);
    chk("err_count_w4", int'(bus4.err_count), (exp_err > 15) ? 15 : exp_err);
    chk("done", int'(bus16.done), int'(exp_done));
    chk("pass", int'(bus16.pass), int'(exp_done && exp_err == 0));
    chk("pass_w4", int'(bus4.pass), int'(exp_done && exp_err == 0));
    chk("busy", int'(bus16.busy), int'(r_h[0] && !exp_done));
    chk("unsupported", int'(bus16.unsupported), int'(u_h[0]));
  endtask

  task automatic step(input bit mu, input int tm, input bit v, input int d);
    @(negedge clk);
    compare_outputs();
    bus16.mode_update = mu;
    bus16.test_mode   = 8'(tm);
    bus16.adc_valid   = v;
    bus16.adc_data    = 8'(d);
    model_step(mu, tm, v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic settle_junk();
    for (int i = 0; i < SETTLE; i++) step(0, 0, 1, $urandom_range(255));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus16.busy), 0);
    chk({tag, "_done"}, int'(bus16.done), 0);
    chk({tag, "_pass"}, int'(bus16.pass), 0);
    chk({tag, "_unsup"}, int'(bus16.unsupported), 0);
    chk({tag, "_err"}, int'(bus16.err_count), 0);
    chk({tag, "_err_w4"}, int'(bus4.err_count), 0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    bus16.mode_update = 0; bus16.adc_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit v, good;
    int mode, d, gphase;
    bus16.mode_update = 0; bus16.test_mode = 0; bus16.adc_valid = 0; bus16.adc_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Midscale: clean stream, done two cycles after the last sample
    step(1, 8'h01, 0, 0);
    settle_junk();
    for (int k = 1; k <= CHECK; k++) step(0, 0, 1, 8'h80);
    idle(2);
    chk("t1_done_early", int'(bus16.done), 0);
    idle(1);
    chk("t1_done", int'(bus16.done), 1);
    chk("t1_pass", int'(bus16.pass), 1);
    chk("t1_err", int'(bus16.err_count), 0);

    // Checkerboard starting on 0xAA with three corrupted samples
    step(1, 8'h04, 0, 0);
    settle_junk();
    for (int k = 1; k <= CHECK; k++)
      step(0, 0, 1, (k == 100 || k == 501 || k == 900) ? 8'h00 : (((k - 1) % 2 == 0) ? 8'hAA : 8'h55));
    idle(3);
    chk("t2_err", int'(bus16.err_count), 3);
    chk("t2_pass", int'(bus16.pass), 0);
    chk("t2_done", int'(bus16.done), 1);
    step(1, 8'h04, 0, 0);
    settle_junk();
    for (int k = 1; k <= CHECK; k++) step(0, 0, 1, ((k - 1) % 2 == 0) ? 8'h55 : 8'hAA);
    idle(3);
    chk("t2b_pass", int'(bus16.pass), 1);

    // +FS with valid gaps
    step(1, 8'h02, 0, 0);
    for (int i = 0; i < SETTLE + CHECK; i++) begin
      step(0, 0, 1, 8'hFF);
      step(0, 0, 0, 8'h00);
      if (i == SETTLE + CHECK - 2) chk("t3_not_done", int'(bus16.done), 0);
    end
    idle(2);
    chk("t3_done", int'(bus16.done), 1);
    chk("t3_pass", int'(bus16.pass), 1);

    // Unsupported codes
    step(1, 8'h00, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 8'h13);
    chk("t4_unsup0", int'(bus16.unsupported), 1);
    chk("t4_busy0", int'(bus16.busy), 0);
    step(1, 8'h05, 0, 0);
    idle(2);
    chk("t4_unsup5", int'(bus16.unsupported), 1);
    chk("t4_done5", int'(bus16.done), 0);
    chk("t4_err5", int'(bus16.err_count), 0);

    // -FS fed all 0xFF: narrow counter saturates
    step(1, 8'h03, 0, 0);
    settle_junk();
    for (int k = 1; k <= CHECK; k++) step(0, 0, 1, 8'hFF);
    idle(3);
    chk("t5_err_w4", int'(bus4.err_count), 15);
    chk("t5_err", int'(bus16.err_count), 1024);
    chk("t5_pass_w4", int'(bus4.pass), 0);

    // Abort mid-CHECK with a coincident sample, then async reset mid-run
    step(1, 8'h01, 0, 0);
    settle_junk();
    for (int k = 1; k <= 200; k++) step(0, 0, 1, (k % 7 == 0) ? 8'h81 : 8'h80);
    step(1, 8'h04, 1, 8'h12);
    step(0, 0, 0, 0);
    chk("t6_err_cleared", int'(bus16.err_count), 0);
    chk("t6_busy", int'(bus16.busy), 1);
    settle_junk();
    for (int k = 1; k <= 50; k++) step(0, 0, 1, (k % 5 == 0) ? 8'h33 : (((k - 1) % 2) ? 8'hAA : 8'h55));
    async_reset();

    // Randomized runs, occasional aborts and corrupted samples
    for (int r = 0; r < 10; r++) begin
      case ($urandom_range(7))
        0: mode = 1; 1: mode = 2; 2: mode = 3; 3: mode = 4; 4: mode = 7;
        5: mode = 4; 6: mode = 7; default: mode = $urandom_range(15);
      endcase
      step(1, mode, $urandom_range(1), $urandom_range(255));
      gphase = $urandom_range(1);
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(4999) == 0) begin
          mode = 4;
          step(1, mode, 1, $urandom_range(255));
        end else begin
          v    = ($urandom_range(3) != 0);
          good = ($urandom_range(15) != 0);
          d    = good ? pattern_value(mode, 1, gphase) : $urandom_range(255);
          if (v) gphase ^= 1;
          step(0, 0, v, d);
        end
        if (m_done || !m_run) break;
      end
      idle(4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
